patch_descriptor_engine: RTL
============================

PATCH_DESCRIPTOR_ENGINE -- requirements
Module: patch_descriptor_engine

Interface
REQ-001 Parameters; each SHALL be one per line:
- BIT_DEPTH, 8, signed gradient width.
- WIDTH, 64, image width in pixels.
- HEIGHT, 64, image height in pixels.
- PATCH_SIZE, 4, patch side P; even, >=4.
- RD_LAT, 2, gradient RAM read latency in cycles.
- MAX_KP, 1000, maximum keypoints per list.
REQ-002 Derived values: S=P/2; CW=$clog2(S*S)+1; descriptor word DW=8*CW.
REQ-003 Ports SHALL be exactly as follows:
- clk_in  in  1  sole clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- kp_valid  in  1  keypoint offered.
- kp_ready  out  1  keypoint accepted when kp_valid&&kp_ready.
- kp_x  in  $clog2(WIDTH)  keypoint column.
- kp_y  in  $clog2(HEIGHT)  keypoint row.
- kp_last  in  1  final keypoint of the list.
- grad_addr  out  $clog2(WIDTH*HEIGHT)  read address, row*WIDTH+col, shared by x and y RAMs.
- x_grad  in  BIT_DEPTH  signed dx, valid RD_LAT cycles after its address.
- y_grad  in  BIT_DEPTH  signed dy, valid RD_LAT cycles after its address.
- desc_wea  out  1  descriptor write strobe.
- desc_write_addr  out  $clog2(MAX_KP*4)  write address = kp_index*4+sub.
- desc_out  out  DW  sub-patch histogram.
- descriptors_done  out  1  one-cycle pulse at end of list.
- kp_count  out  $clog2(MAX_KP+1)  keypoints processed (stats).
- oob_count  out  16  out-of-bounds pixels skipped (stats).

Function
REQ-004 FSM states SHALL be IDLE, SCAN, DRAIN, EMIT, DONE. kp_ready SHALL be 1 only in IDLE.
REQ-005 IDLE->SCAN on handshake. Handshake latches kp_x, kp_y and kp_last, and clears all 4x8 histogram counters.
REQ-006 SCAN SHALL run P*P cycles, visiting patch pixels row-major.
- Pixel coordinates: (kp_x-S+c, kp_y-S+r), r,c in 0..P-1.
- Sub-patch index: sub={r>=S, c>=S}.
REQ-007 An out-of-bounds pixel (col<0, col>=WIDTH, row<0, row>=HEIGHT) SHALL be skipped. Its slot issues no counted sample, but the scan still takes one cycle for it.
REQ-008 A tag shift register of depth RD_LAT SHALL carry {in-bounds, sub} so each returned sample is paired with its pixel.
REQ-009 Bin SHALL be {dy<0, dx<0, |dy|>|dx|}, with magnitudes computed at BIT_DEPTH+1 bits so -128 is handled. Samples with dx==0 and dy==0 SHALL not be counted.
REQ-010 Each counted sample SHALL increment counter [sub][bin] on the cycle after its data is valid. Counters cannot overflow, since CW holds S*S.
REQ-011 SCAN->DRAIN after the last address. DRAIN SHALL last RD_LAT+1 cycles, until the final sample is accumulated.
REQ-012 EMIT SHALL last 4 cycles with desc_wea=1, sub=0..3 in order.
- desc_out bits [b*CW +: CW] = count of bin b.
- First desc_wea SHALL occur exactly P*P+RD_LAT+2 cycles after the handshake cycle.
REQ-013 After EMIT:
- kp_index SHALL increment.
- If latched kp_last: go to DONE, then DONE->IDLE after 1 cycle with descriptors_done=1 and kp_index cleared.
- Otherwise: go to IDLE.
REQ-014 If kp_index reaches MAX_KP without kp_last, it SHALL wrap to 0.
REQ-015 grad_addr SHALL hold its last value outside SCAN. desc_wea and descriptors_done SHALL be 0 outside EMIT and DONE respectively.

Reset
REQ-016 rst_n_in low SHALL immediately force:
- FSM to IDLE.
- kp_index, histograms, tag register, desc_wea, descriptors_done, grad_addr, desc_write_addr, desc_out, kp_count and oob_count to 0.
REQ-017 A reset mid-SCAN, DRAIN or EMIT SHALL abort the keypoint with no further writes. kp_ready SHALL be 1 on the first clock after release.

Configuration
REQ-018 With macro DESC_STATS_EN defined:
- kp_count SHALL increment per completed EMIT and clear on descriptors_done.
- oob_count SHALL increment per skipped pixel, saturate at 65535 and clear on descriptors_done.
REQ-019 Without DESC_STATS_EN, both outputs SHALL be tied to 0 and no counter logic SHALL be synthesised. All other behaviour is unchanged.

Structure
REQ-020 Package sift_desc_pkg SHALL hold the FSM state enum, the NUM_BINS=8 constant and the bin-index function.
REQ-021 Sub-module grad_binner SHALL map (dx, dy, tag-valid) to (bin, count-enable) combinationally. It is instantiated once.

Verification (P=4, WIDTH=HEIGHT=64, RD_LAT=2)
REQ-022 Keypoint (10,10), all dx=+5, dy=+1 -> 4 writes at addr 0..3, each desc_out bin0=4 and other bins 0. First write 20 cycles after the handshake.
REQ-023 Keypoint (0,0), dx=+5, dy=+1 -> sub 0..2 all zero; sub3 bin0=4. oob_count=12 with DESC_STATS_EN.
REQ-024 dx=-3, dy=-7 everywhere -> bin7=4 in each sub-patch; dx=dy=0 everywhere -> all words zero.
REQ-025 Two keypoints, second with kp_last -> writes at addr 0..7. descriptors_done pulses 1 cycle after the addr-7 write. A third keypoint then writes at addr 0.
REQ-026 rst_n_in low for 1 cycle at SCAN cycle 5 -> no desc_wea follows; kp_ready=1 after release; the next keypoint writes at addr 0.

Source files
------------

// File: rtl/sift_desc_pkg.sv
// Shared types and helpers for the patch descriptor engine.
// Holds the FSM state encoding, histogram bin count and bin-index mapping.
package sift_desc_pkg;

    localparam int NUM_BINS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EMIT,
        DONE
    } state_e;

    // Bin = {dy negative, dx negative, dy dominates dx}.
    function automatic logic [2:0] bin_index(input logic dy_neg, input logic dx_neg, input logic dy_dom);
        return {dy_neg, dx_neg, dy_dom};
    endfunction

endpackage

// File: rtl/grad_binner.sv
// Maps one returned gradient sample to its orientation bin and count enable.
// Latency: combinational. Backpressure: none, evaluated every cycle.
// Magnitudes use one extra bit so the most negative code folds correctly.
module grad_binner
    import sift_desc_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic signed [BIT_DEPTH-1:0] dx,
    input  logic signed [BIT_DEPTH-1:0] dy,
    input  logic                        tag_vld,
    output logic [2:0]                  bin,
    output logic                        cnt_en
);

    logic [BIT_DEPTH:0] dx_ext, dy_ext, mag_dx, mag_dy;

    always_comb begin
        dx_ext = {dx[BIT_DEPTH-1], dx};
        dy_ext = {dy[BIT_DEPTH-1], dy};
        mag_dx = dx[BIT_DEPTH-1] ? -dx_ext : dx_ext;
        mag_dy = dy[BIT_DEPTH-1] ? -dy_ext : dy_ext;
        bin    = bin_index(dy[BIT_DEPTH-1], dx[BIT_DEPTH-1], mag_dy > mag_dx);
        cnt_en = tag_vld && ((dx != '0) || (dy != '0));
    end

endmodule

// File: rtl/patch_descriptor_engine.sv
// Builds a 4-sub-patch gradient-orientation descriptor per keypoint; optional stats via DESC_STATS_EN.
// Latency: first descriptor write P*P+RD_LAT+2 cycles after the keypoint handshake, then 4 writes.
// Backpressure: kp_ready only in IDLE; descriptor writes are unconditional strobes.
module patch_descriptor_engine
    import sift_desc_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int PATCH_SIZE = 4,
    parameter int RD_LAT     = 2,
    parameter int MAX_KP     = 1000,
    localparam int S         = PATCH_SIZE / 2,
    localparam int CW        = $clog2(S * S) + 1,
    localparam int DW        = 8 * CW
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              kp_valid,
    output logic                              kp_ready,
    input  logic [$clog2(WIDTH)-1:0]          kp_x,
    input  logic [$clog2(HEIGHT)-1:0]         kp_y,
    input  logic                              kp_last,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   grad_addr,
    input  logic signed [BIT_DEPTH-1:0]       x_grad,
    input  logic signed [BIT_DEPTH-1:0]       y_grad,
    output logic                              desc_wea,
    output logic [$clog2(MAX_KP*4)-1:0]       desc_write_addr,
    output logic [DW-1:0]                     desc_out,
    output logic                              descriptors_done,
    output logic [$clog2(MAX_KP+1)-1:0]       kp_count,
    output logic [15:0]                       oob_count
);

    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int AW   = $clog2(WIDTH * HEIGHT);
    localparam int KIW  = $clog2(MAX_KP);
    localparam int WAW  = $clog2(MAX_KP * 4);
    localparam int RCW  = $clog2(PATCH_SIZE);
    localparam int CNTW = $clog2(RD_LAT + 4);
    localparam logic [RCW-1:0]  LAST_RC   = RCW'(PATCH_SIZE - 1);
    localparam logic [RCW-1:0]  HALF      = RCW'(S);
    localparam logic [CNTW-1:0] DRAIN_END = CNTW'(RD_LAT);
    localparam logic [CNTW-1:0] EMIT_END  = CNTW'(3);
    localparam logic [KIW-1:0]  KP_WRAP   = KIW'(MAX_KP - 1);

    typedef struct packed {
        logic       ib;
        logic [1:0] sub;
    } tag_t;

    state_e                              state_q, state_d;
    logic [XW-1:0]                       kx_q, kx_d;
    logic [YW-1:0]                       ky_q, ky_d;
    logic                                last_q, last_d;
    logic [RCW-1:0]                      r_q, r_d, c_q, c_d;
    logic [CNTW-1:0]                     cnt_q, cnt_d;
    tag_t                                cur_q, cur_d;
    tag_t [RD_LAT-1:0]                   tag_q, tag_d;
    logic [3:0][NUM_BINS-1:0][CW-1:0]    hist_q, hist_d;
    logic [AW-1:0]                       grad_addr_q, grad_addr_d;
    logic                                desc_wea_q, desc_wea_d;
    logic [WAW-1:0]                      waddr_q, waddr_d;
    logic [DW-1:0]                       dout_q, dout_d;
    logic                                done_q, done_d;
    logic [KIW-1:0]                      kpi_q, kpi_d;
    logic [1:0]                          nsub;
    logic                                issue, in_b, cnt_en;
    logic [2:0]                          bin;
    tag_t                                tag_out;
    int                                  col, row;

    assign tag_out = tag_q[RD_LAT-1];
    assign nsub    = cnt_q[1:0] + 2'd1;

    grad_binner #(.BIT_DEPTH(BIT_DEPTH)) u_grad_binner (
        .dx      (x_grad),
        .dy      (y_grad),
        .tag_vld (tag_out.ib),
        .bin     (bin),
        .cnt_en  (cnt_en)
    );

    always_comb begin
        state_d     = state_q;
        kx_d        = kx_q;
        ky_d        = ky_q;
        last_d      = last_q;
        r_d         = r_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        cur_d       = '0;
        grad_addr_d = grad_addr_q;
        desc_wea_d  = 1'b0;
        waddr_d     = waddr_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        kpi_d       = kpi_q;
        issue       = 1'b0;
        tag_d[0]    = cur_q;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
        hist_d = hist_q;
        if (cnt_en) hist_d[tag_out.sub][bin] = hist_q[tag_out.sub][bin] + CW'(1);

        case (state_q)
            IDLE: if (kp_valid) begin
                kx_d    = kp_x;
                ky_d    = kp_y;
                last_d  = kp_last;
                r_d     = '0;
                c_d     = '0;
                hist_d  = '0;
                issue   = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (r_q == LAST_RC && c_q == LAST_RC) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end else begin
                issue = 1'b1;
                if (c_q == LAST_RC) begin
                    c_d = '0;
                    r_d = r_q + RCW'(1);
                end else begin
                    c_d = c_q + RCW'(1);
                end
            end
            // Final sample lands in hist_q on the last DRAIN cycle.
            DRAIN: if (cnt_q == DRAIN_END) begin
                state_d    = EMIT;
                cnt_d      = '0;
                desc_wea_d = 1'b1;
                waddr_d    = {kpi_q, 2'b00};
                dout_d     = hist_q[0];
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
            EMIT: if (cnt_q == EMIT_END) begin
                kpi_d = (kpi_q == KP_WRAP) ? '0 : kpi_q + KIW'(1);
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d      = cnt_q + CNTW'(1);
                desc_wea_d = 1'b1;
                waddr_d    = {kpi_q, nsub};
                dout_d     = hist_q[nsub];
            end
            DONE: begin
                kpi_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        col  = int'(kx_d) + int'(c_d) - S;
        row  = int'(ky_d) + int'(r_d) - S;
        in_b = (col >= 0) && (col < WIDTH) && (row >= 0) && (row < HEIGHT);
        // Skipped pixels leave the address bus untouched.
        if (issue) begin
            cur_d.ib  = in_b;
            cur_d.sub = {r_d >= HALF, c_d >= HALF};
            if (in_b) grad_addr_d = AW'(row * WIDTH + col);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            kx_q        <= '0;
            ky_q        <= '0;
            last_q      <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            cur_q       <= '0;
            tag_q       <= '0;
            hist_q      <= '0;
            grad_addr_q <= '0;
            desc_wea_q  <= 1'b0;
            waddr_q     <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            kpi_q       <= '0;
        end else begin
            state_q     <= state_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            last_q      <= last_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            tag_q       <= tag_d;
            hist_q      <= hist_d;
            grad_addr_q <= grad_addr_d;
            desc_wea_q  <= desc_wea_d;
            waddr_q     <= waddr_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            kpi_q       <= kpi_d;
        end
    end

    assign kp_ready         = (state_q == IDLE);
    assign grad_addr        = grad_addr_q;
    assign desc_wea         = desc_wea_q;
    assign desc_write_addr  = waddr_q;
    assign desc_out         = dout_q;
    assign descriptors_done = done_q;

`ifdef DESC_STATS_EN
    logic [$clog2(MAX_KP+1)-1:0] kp_count_q, kp_count_d;
    logic [15:0]                 oob_count_q, oob_count_d;

    always_comb begin
        kp_count_d  = kp_count_q;
        oob_count_d = oob_count_q;
        if (state_q == DONE) begin
            kp_count_d  = '0;
            oob_count_d = '0;
        end else begin
            if (state_q == EMIT && cnt_q == EMIT_END) kp_count_d = kp_count_q + 1'b1;
            if (issue && !in_b && oob_count_q != 16'hFFFF) oob_count_d = oob_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            kp_count_q  <= '0;
            oob_count_q <= '0;
        end else begin
            kp_count_q  <= kp_count_d;
            oob_count_q <= oob_count_d;
        end
    end

    assign kp_count  = kp_count_q;
    assign oob_count = oob_count_q;
`else
    assign kp_count  = '0;
    assign oob_count = '0;
`endif

endmodule
